// File: rtl/rx_l3_dispatch.sv
// Receive-side L3 dispatcher: EtherType steering, IPv4 header sanity and pad trimming.
// Optional ARP path enabled by defining RX_ARP_EN.
module rx_l3_dispatch #(
  parameter int OCT   = 8,
  parameter int CNT_W = 16
) (
  input  logic             RX_CLK,
  input  logic             rst_n,
  input  logic [15:0]      rx_ethertype,
  input  logic             rx_mac_valid,
  input  logic [OCT-1:0]   rx_mac_data,
  output logic             rx_payload_ipv4,
`ifdef RX_ARP_EN
  output logic             rx_payload_arp,
`endif
  output logic [OCT-1:0]   rx_payload,
  output logic             rx_ipv4_done,
  output logic             rx_ipv4_err,
  output logic [CNT_W-1:0] rx_drop_cnt
);

  // state | meaning
  // SKIP  | discard a frame in flight at reset release
  // IDLE  | wait for first byte, dispatch on EtherType
  // HDR   | IPv4 bytes 1..3, latch Total Length
  // BODY  | forward until Total Length bytes sent
  // PAD   | discard Ethernet padding
  // ARP   | forward whole ARP frame (RX_ARP_EN only)
  // DROP  | discard rest of rejected frame
  typedef enum logic [2:0] {
    S_SKIP, S_IDLE, S_HDR, S_BODY, S_PAD,
`ifdef RX_ARP_EN
    S_ARP,
`endif
    S_DROP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ipv4, w_ipv4_nxt;
  logic             r_arp, w_arp_nxt;
  logic [OCT-1:0]   r_payload, w_payload_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic [15:0]      r_tl, w_tl_nxt;
  logic [3:0]       r_ihl, w_ihl_nxt;
  logic             r_done_pend, r_done, w_done_set;
  logic             r_err_pend, r_err, w_err_set, w_trunc;
  logic             w_drop;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [15:0]      w_tl_full;

  assign w_tl_full = {r_tl[15:8], rx_mac_data[7:0]};

  always_comb begin
    w_state_nxt   = r_state;
    w_ipv4_nxt    = 1'b0;
    w_arp_nxt     = 1'b0;
    w_payload_nxt = r_payload;
    w_cnt_nxt     = r_cnt;
    w_tl_nxt      = r_tl;
    w_ihl_nxt     = r_ihl;
    w_done_set    = 1'b0;
    w_err_set     = 1'b0;
    w_trunc       = 1'b0;
    w_drop        = 1'b0;
    case (r_state)
      S_SKIP: if (!rx_mac_valid) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (rx_mac_valid) begin
          if (rx_ethertype == 16'h0800) begin
            if (rx_mac_data[7:4] == 4'd4 && rx_mac_data[3:0] >= 4'd5) begin
              w_ipv4_nxt    = 1'b1;
              w_payload_nxt = rx_mac_data;
              w_cnt_nxt     = 16'd1;
              w_ihl_nxt     = rx_mac_data[3:0];
              w_state_nxt   = S_HDR;
            end else begin
              w_drop      = 1'b1;
              w_state_nxt = S_DROP;
            end
          end
`ifdef RX_ARP_EN
          else if (rx_ethertype == 16'h0806) begin
            w_arp_nxt     = 1'b1;
            w_payload_nxt = rx_mac_data;
            w_state_nxt   = S_ARP;
          end
`endif
          else begin
            w_drop      = 1'b1;
            w_state_nxt = S_DROP;
          end
        end
      end
      S_HDR: begin
        if (!rx_mac_valid) begin
          w_trunc     = 1'b1;
          w_drop      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_ipv4_nxt    = 1'b1;
          w_payload_nxt = rx_mac_data;
          w_cnt_nxt     = r_cnt + 16'd1;
          if (r_cnt == 16'd2) begin
            w_tl_nxt = {rx_mac_data[7:0], r_tl[7:0]};
          end else if (r_cnt == 16'd3) begin
            w_tl_nxt = w_tl_full;
            // Header longer than the datagram claims: byte 3 still goes out, then abort
            if (w_tl_full < {10'd0, r_ihl, 2'b00}) begin
              w_err_set   = 1'b1;
              w_drop      = 1'b1;
              w_state_nxt = S_DROP;
            end else begin
              w_state_nxt = S_BODY;
            end
          end
        end
      end
      S_BODY: begin
        if (!rx_mac_valid) begin
          w_trunc     = 1'b1;
          w_drop      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_ipv4_nxt    = 1'b1;
          w_payload_nxt = rx_mac_data;
          w_cnt_nxt     = r_cnt + 16'd1;
          if (r_cnt + 16'd1 == r_tl) begin
            w_done_set  = 1'b1;
            w_state_nxt = S_PAD;
          end
        end
      end
`ifdef RX_ARP_EN
      S_ARP: begin
        if (rx_mac_valid) begin
          w_arp_nxt     = 1'b1;
          w_payload_nxt = rx_mac_data;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      S_PAD, S_DROP: if (!rx_mac_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_SKIP;
    endcase
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_SKIP;
      r_ipv4      <= 1'b0;
      r_arp       <= 1'b0;
      r_payload   <= '0;
      r_cnt       <= 16'd0;
      r_tl        <= 16'd0;
      r_ihl       <= 4'd0;
      r_done_pend <= 1'b0;
      r_done      <= 1'b0;
      r_err_pend  <= 1'b0;
      r_err       <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ipv4      <= w_ipv4_nxt;
      r_arp       <= w_arp_nxt;
      r_payload   <= w_payload_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tl        <= w_tl_nxt;
      r_ihl       <= w_ihl_nxt;
      r_done_pend <= w_done_set;
      r_done      <= r_done_pend;
      r_err_pend  <= w_err_set;
      r_err       <= r_err_pend | w_trunc;
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign rx_payload_ipv4 = r_ipv4;
`ifdef RX_ARP_EN
  assign rx_payload_arp  = r_arp;
`endif
  assign rx_payload      = r_payload;
  assign rx_ipv4_done    = r_done;
  assign rx_ipv4_err     = r_err;
  assign rx_drop_cnt     = r_drop_cnt;

`ifndef RX_ARP_EN
  logic w_unused;
  assign w_unused = r_arp;
`endif

endmodule
